// File: rtl/apb_slave_regfile.sv
// APB slave register bank: NUM_REGS 32-bit registers, register 0 is a read-only ID,
// fixed wait-state count per access and PSLVERR on bad address or ID write.
module apb_slave_regfile #(
  parameter int unsigned  NUM_REGS    = 8,
  parameter int unsigned  WAIT_STATES = 2,
  parameter logic [31:0]  ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [31:0]             PADDR,
  input  logic [31:0]             PWDATA,
  output logic [31:0]             PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [32*NUM_REGS-1:0]  REGS_FLAT
);

  localparam int unsigned IDX_W    = $clog2(NUM_REGS);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pready;

  logic [31:0] regs     [1:NUM_REGS-1];
  logic [31:0] reg_view [NUM_REGS];

  logic [IDX_W-1:0] idx;
  logic             misaligned, out_of_range, id_write, err;
  logic             wr_en;

  // Address decode works directly off the bus; the master holds it stable.
  assign idx          = PADDR[2 +: IDX_W];
  assign misaligned   = |PADDR[1:0];
  assign out_of_range = |PADDR[31:2+IDX_W];
  assign id_write     = PWRITE && (idx == '0);
  assign err          = misaligned || out_of_range || id_write;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = S_ACCESS;
          cnt_d   = WAIT_CNT;
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (!PENABLE) begin
          // A fresh setup phase while in access restarts the wait count.
          cnt_d = WAIT_CNT;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          pready  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  assign wr_en = pready && PWRITE && !err;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (wr_en && (idx == IDX_W'(i))) begin
          regs[i] <= PWDATA;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_view
    if (g == 0) begin : g_id
      assign reg_view[g] = ID_VALUE;
    end else begin : g_reg
      assign reg_view[g] = regs[g];
    end
    assign REGS_FLAT[32*g +: 32] = reg_view[g];
  end

  assign PREADY  = pready;
  assign PSLVERR = pready && err;
  assign PRDATA  = (pready && !PWRITE && !err) ? reg_view[idx] : '0;

endmodule
